// File: rtl/hlsm_param_kernel.sv
// Parameterised HLSM kernel: z = max/min(a+b, a+c), x = a*c - (a+b), Start/Done handshake.
// Define HLSM_SAT_EN to clamp x at zero instead of wrapping when a*c < a+b.
module hlsm_param_kernel #(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 3
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 Mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 Busy,
  output logic                 Done,
  output logic [WIDTH:0]       z,
  output logic [2*WIDTH-1:0]   x
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  typedef enum logic [2:0] {IDLE, ADD, CMP, SEL, MUL, SUB, FIN} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic                 rmode_q, rmode_d;
  logic [WIDTH:0]       d_q, d_d, e_q, e_d, z_q, z_d;
  logic [2*WIDTH-1:0]   f_q, f_d, x_q, x_d;
  logic                 g_q, g_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [2*WIDTH-1:0]   d_ext;

  assign d_ext = {{(WIDTH-1){1'b0}}, d_q};

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    rmode_d = rmode_q;
    d_d     = d_q;
    e_d     = e_q;
    f_d     = f_q;
    g_d     = g_q;
    z_d     = z_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          ra_d    = a;
          rb_d    = b;
          rc_d    = c;
          rmode_d = Mode;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        d_d     = {1'b0, ra_q} + {1'b0, rb_q};
        e_d     = {1'b0, ra_q} + {1'b0, rc_q};
        state_d = CMP;
      end
      CMP: begin
        g_d     = (d_q > e_q);
        state_d = SEL;
      end
      SEL: begin
        // g XOR mode picks d for (max, d>e) and (min, d<=e); ties yield e == d.
        z_d     = (g_q ^ rmode_q) ? d_q : e_q;
        cnt_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          f_d     = {{WIDTH{1'b0}}, ra_q} * {{WIDTH{1'b0}}, rc_q};
          state_d = SUB;
        end
      end
      SUB: begin
`ifdef HLSM_SAT_EN
        x_d = (f_q >= d_ext) ? (f_q - d_ext) : '0;
`else
        x_d = f_q - d_ext;
`endif
        state_d = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      rmode_q <= 1'b0;
      d_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      g_q     <= 1'b0;
      z_q     <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      rmode_q <= rmode_d;
      d_q     <= d_d;
      e_q     <= e_d;
      f_q     <= f_d;
      g_q     <= g_d;
      z_q     <= z_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign z    = z_q;
  assign x    = x_q;

endmodule

// File: tb/tb_hlsm_param_kernel.sv
// Directed bench for hlsm_param_kernel: MUL_LAT=3 instance plus a MUL_LAT=1 instance.
module tb_hlsm_param_kernel;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start, Mode;
  logic [15:0] a, b, c;
  logic        Busy, Done;
  logic [16:0] z;
  logic [31:0] x;

  logic        s1_start, s1_mode;
  logic [15:0] s1_a, s1_b, s1_c;
  logic        s1_busy, s1_done;
  logic [16:0] s1_z;
  logic [31:0] s1_x;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  hlsm_param_kernel #(.WIDTH(16), .MUL_LAT(3)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode),
    .a(a), .b(b), .c(c), .Busy(Busy), .Done(Done), .z(z), .x(x)
  );

  hlsm_param_kernel #(.WIDTH(16), .MUL_LAT(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Start(s1_start), .Mode(s1_mode),
    .a(s1_a), .b(s1_b), .c(s1_c), .Busy(s1_busy), .Done(s1_done), .z(s1_z), .x(s1_x)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Issue one operation on the MUL_LAT=3 instance and check latency, handshake and results.
  task automatic run_op(input string tag, input logic [15:0] ia, ib, ic, input logic im,
                        input logic [16:0] ez, input logic [31:0] ex);
    int n;
    a = ia; b = ib; c = ic; Mode = im; Start = 1'b1;
    tick();
    Start = 1'b0;
    a = ~ia; b = ~ib; c = ~ic; Mode = ~im;
    check({tag, "_busy"}, Busy, 1);
    n = 0;
    while (!Done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 8);
    check({tag, "_z"}, z, ez);
    check({tag, "_x"}, x, ex);
    check({tag, "_busy_at_done"}, Busy, 0);
    tick();
    check({tag, "_done_clr"}, Done, 0);
  endtask

  initial begin
    int n, ndone;
    int done_at[$];
    Rst = 1'b1; Start = 1'b0; Mode = 1'b0; a = '0; b = '0; c = '0;
    s1_start = 1'b0; s1_mode = 1'b0; s1_a = '0; s1_b = '0; s1_c = '0;
    tick(); tick();
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_z", z, 0);
    check("rst_x", x, 0);
    check("rst1_busy", s1_busy, 0);
    Rst = 1'b0;
    tick();

    run_op("max", 16'd3, 16'd4, 16'd10, 1'b0, 17'd13, 32'd23);
    run_op("min", 16'd3, 16'd4, 16'd10, 1'b1, 17'd7, 32'd23);
    run_op("tie0", 16'd5, 16'd5, 16'd5, 1'b0, 17'd10, 32'd15);
    run_op("tie1", 16'd5, 16'd5, 16'd5, 1'b1, 17'd10, 32'd15);
`ifdef HLSM_SAT_EN
    run_op("wrap", 16'd1, 16'hFFFF, 16'd0, 1'b0, 17'h10000, 32'h0);
`else
    run_op("wrap", 16'd1, 16'hFFFF, 16'd0, 1'b0, 17'h10000, 32'hFFFF0000);
`endif

    // Start pulses at k+2 and k+5 with different operands must be ignored.
    a = 16'd3; b = 16'd4; c = 16'd10; Mode = 1'b0; Start = 1'b1;
    tick();                                       // edge k
    Start = 1'b0; a = 16'd100; b = 16'd200; c = 16'd300; Mode = 1'b1;
    tick();                                       // k+1
    Start = 1'b1;
    tick();                                       // k+2
    Start = 1'b0;
    tick(); tick();                               // k+3, k+4
    Start = 1'b1;
    tick();                                       // k+5
    Start = 1'b0;
    ndone = 0;
    for (int i = 6; i <= 24; i++) begin
      tick();
      if (Done) begin
        ndone++;
        check("ign_lat", i, 8);
        check("ign_z", z, 13);
        check("ign_x", x, 23);
      end
    end
    check("ign_count", ndone, 1);

    // Start held through the Done cycle: accepts at k and k+9.
    a = 16'd3; b = 16'd4; c = 16'd10; Mode = 1'b0; Start = 1'b1;
    tick();                                       // edge k
    a = 16'd5; b = 16'd5; c = 16'd5;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 9) begin
        Start = 1'b0;
        check("b2b_busy_k9", Busy, 1);
      end
      if (Done) begin
        done_at.push_back(i);
        if (done_at.size() == 1) begin
          check("b2b_z1", z, 13);
          check("b2b_x1", x, 23);
        end else begin
          check("b2b_z2", z, 10);
          check("b2b_x2", x, 15);
        end
      end
    end
    check("b2b_count", done_at.size(), 2);
    if (done_at.size() == 2) begin
      check("b2b_first", done_at[0], 8);
      check("b2b_second", done_at[1], 17);
    end

    // Reset mid-operation at k+5 discards the operation.
    a = 16'd3; b = 16'd4; c = 16'd10; Mode = 1'b0; Start = 1'b1;
    tick();                                       // edge k
    Start = 1'b0;
    tick(); tick(); tick(); tick();               // k+1..k+4 (z written at k+3)
    Rst = 1'b1;
    tick();                                       // k+5
    Rst = 1'b0;
    check("mrst_busy", Busy, 0);
    check("mrst_done", Done, 0);
    check("mrst_z", z, 0);
    check("mrst_x", x, 0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Done) ndone++;
    end
    check("mrst_no_done", ndone, 0);
    run_op("after_rst", 16'd3, 16'd4, 16'd10, 1'b1, 17'd7, 32'd23);

    // MUL_LAT=1 instance.
    s1_a = 16'hFFFF; s1_b = 16'd0; s1_c = 16'hFFFF; s1_mode = 1'b0; s1_start = 1'b1;
    tick();
    s1_start = 1'b0; s1_a = '0; s1_c = '0;
    check("m1_busy", s1_busy, 1);
    n = 0;
    while (!s1_done && n < 40) begin
      tick();
      n++;
    end
    check("m1_lat", n, 6);
    check("m1_z", s1_z, 17'h1FFFE);
    check("m1_x", s1_x, 32'hFFFD0002);
    tick();
    check("m1_done_clr", s1_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
